// File: rtl/divisor_pkg.sv
// divisor_pkg: shared state encoding and default width for the divider
package divisor_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int n_def = 19;
endpackage

// File: rtl/divisor_if.sv
// divisor_if: request/result bundle between a divider client and the divider
interface divisor_if import divisor_pkg::*; #(parameter int n = n_def);
  logic start;
  logic [n-1:0] A, B, out, rem;
  logic busy, done, overflow, div_cero, car;
  modport master(output start, A, B, input out, rem, busy, done, overflow, div_cero, car);
  modport slave(input start, A, B, output out, rem, busy, done, overflow, div_cero, car);
endinterface

// File: rtl/divisor_paso_division.sv
// paso_division: one combinational restoring-division step on n+1-bit magnitudes
module paso_division import divisor_pkg::*; #(parameter int n = n_def) (
  input  logic [n:0] r,
  input  logic       db,
  input  logic [n:0] d,
  output logic [n:0] r_nx,
  output logic       q
);
  logic [n+1:0] diff;
  // the borrow out of the trial subtraction decides the quotient bit
  assign diff = {r, db} - {1'b0, d};
  assign q = ~diff[n+1];
  assign r_nx = q ? diff[n:0] : {r[n-1:0], db};
endmodule

// File: rtl/divisor.sv
// divisor: fixed-latency signed restoring divider, one quotient bit per cycle
module divisor import divisor_pkg::*; #(parameter int n = n_def) (
  input logic clk,
  input logic rst,
  divisor_if.slave bus
);
  localparam int cw = $clog2(n);
  localparam logic [n-1:0] minv = {1'b1, {(n-1){1'b0}}};
  state_t state, nxt;
  logic ld, qb, qneg, ovf, b0, last;
  logic [cw-1:0] cnt;
  logic [n-1:0] a_r, b_r, dq, qf;
  logic [n:0] r, mb, r_nx;
  paso_division #(.n(n)) u_paso (.r(r), .db(dq[n-1]), .d(mb), .r_nx(r_nx), .q(qb));
  assign last = cnt == cw'(n-1);
  assign qf = {dq[n-2:0], qb};
  assign b0 = b_r == '0;
  assign ovf = a_r == minv && b_r == '1;
  assign qneg = (a_r[n-1] ^ b_r[n-1]) && qf != '0;
  assign bus.car = 1'b0;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (bus.start ? CALC : IDLE) :
          state == CALC ? (!ld && last ? DONE : CALC) : IDLE;
    bus.busy = state == CALC;
    bus.done = state == DONE;
  end
  // the cycle after acceptance converts operands to magnitudes, keeping latency fixed at n+1
  always_ff @(posedge clk) begin
    if (rst) begin
      ld <= 1'b0;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      dq <= '0;
      r <= '0;
      mb <= '0;
      bus.out <= '0;
      bus.rem <= '0;
      bus.overflow <= 1'b0;
      bus.div_cero <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      a_r <= bus.A;
      b_r <= bus.B;
      ld <= 1'b1;
      cnt <= '0;
      bus.overflow <= 1'b0;
      bus.div_cero <= 1'b0;
    end else if (state == CALC && ld) begin
      ld <= 1'b0;
      dq <= a_r[n-1] ? -a_r : a_r;
      mb <= b_r[n-1] ? -{1'b1, b_r} : {1'b0, b_r};
      r <= '0;
    end else if (state == CALC) begin
      r <= r_nx;
      dq <= qf;
      cnt <= cnt + 1'b1;
      if (last) begin
        bus.div_cero <= b0;
        bus.overflow <= ovf && !b0;
        bus.out <= b0 ? '1 : ovf ? a_r : qneg ? -qf : qf;
        bus.rem <= b0 ? a_r : ovf ? '0 : a_r[n-1] ? -r_nx[n-1:0] : r_nx[n-1:0];
      end
    end
  end
endmodule

// File: tb/tb_divisor.sv
// tb_divisor: directed checks of the signed divider at n=19
module tb_divisor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc;
  divisor_if #(.n(19)) bus();
  divisor #(.n(19)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [18:0] a, input logic [18:0] b);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int c);
    c = 0;
    while (!bus.done && c < 40) begin
      tick();
      c++;
    end
  endtask
  task automatic results(input string tag, input logic [18:0] eo, input logic [18:0] er,
                         input logic eov, input logic ed0);
    chk({tag, "_out"}, 32'(bus.out), 32'(eo));
    chk({tag, "_rem"}, 32'(bus.rem), 32'(er));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(eov));
    chk({tag, "_d0"}, 32'(bus.div_cero), 32'(ed0));
  endtask
  task automatic run(input string tag, input logic [18:0] a, input logic [18:0] b,
                     input logic [18:0] eo, input logic [18:0] er, input logic eov, input logic ed0);
    int c;
    go(a, b);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(c);
    chk({tag, "_lat"}, 32'(c), 32'd20);
    chk({tag, "_donebusy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_car"}, 32'(bus.car), 32'd0);
    results(tag, eo, er, eov, ed0);
    tick();
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
    results({tag, "_hold"}, eo, er, eov, ed0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    results("rst", 19'h0, 19'h0, 1'b0, 1'b0);
    run("pos", 19'd100, 19'd7, 19'd14, 19'd2, 1'b0, 1'b0);
    run("nega", 19'h7FF9C, 19'd7, 19'h7FFF2, 19'h7FFFE, 1'b0, 1'b0);
    run("negb", 19'd100, 19'h7FFF9, 19'h7FFF2, 19'd2, 1'b0, 1'b0);
    run("div0", 19'd5, 19'd0, 19'h7FFFF, 19'd5, 1'b0, 1'b1);
    run("ovf", 19'h40000, 19'h7FFFF, 19'h40000, 19'd0, 1'b1, 1'b0);
    run("zero", 19'd0, 19'd5, 19'd0, 19'd0, 1'b0, 1'b0);
    run("bothneg", 19'h7FFFA, 19'h7FFFD, 19'd2, 19'd0, 1'b0, 1'b0);
    run("max", 19'h3FFFF, 19'd1, 19'h3FFFF, 19'd0, 1'b0, 1'b0);
    go(19'd100, 19'd7);
    tick();
    tick();
    go(19'd1000, 19'd3);
    wait_done(cyc);
    chk("ign_lat", 32'(cyc), 32'd17);
    results("ign", 19'd14, 19'd2, 1'b0, 1'b0);
    bus.A = 19'd9;
    bus.B = 19'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("done_start_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("done_start_idle", 32'(bus.busy), 32'd0);
    results("done_start", 19'd14, 19'd2, 1'b0, 1'b0);
    go(19'd100, 19'd7);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    results("abort", 19'h0, 19'h0, 1'b0, 1'b0);
    wait_done(cyc);
    chk("abort_nodone", 32'(cyc), 32'd40);
    run("after", 19'h7FFF9, 19'd2, 19'h7FFFD, 19'h7FFFF, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
